// File: rtl/upower_multicycle_ctrl.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer for the uPower datapath.
// Optional memory-ack watchdog is built in when UPWR_MEM_TIMEOUT_EN is defined.
module upower_multicycle_ctrl #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      instr,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             branch,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [5:0]       opcode_o,
    output logic [9:0]       xox_o,
    output logic [8:0]       xoxo_o,
    output logic             alu_en,
    output logic             reg_we,
    output logic             wb_sel,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             busy,
    output logic             illegal,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU   = 3'd0,
        CLS_LOAD  = 3'd1,
        CLS_STORE = 3'd2,
        CLS_BR    = 3'd3,
        CLS_JMP   = 3'd4,
        CLS_ILL   = 3'd5
    } cls_t;

    state_t           r_state;
    state_t           w_next_state;
    state_t           w_after_end;
    cls_t             w_cls;
    logic [5:0]       r_opcode;
    logic [9:0]       r_xo;
    logic [CNT_W-1:0] r_retired;
    logic             r_illegal;
    logic             r_err;
    logic             w_end;
    logic             w_swu;
    logic             w_timeout;
    logic             w_unused_instr;

    // The XO field is carried as instr[10:1]; the 9-bit form is its low bits.
    function automatic cls_t decode_cls(input logic [5:0] op, input logic [9:0] xo);
        cls_t c;
        case (op)
            6'd31: begin
                if ((xo[8:0] == 9'd266) || (xo[8:0] == 9'd40)) begin
                    c = CLS_ALU;
                end else if ((xo == 10'd28) || (xo == 10'd476) || (xo == 10'd444) ||
                             (xo == 10'd316) || (xo == 10'd986)) begin
                    c = CLS_ALU;
                end else begin
                    c = CLS_ILL;
                end
            end
            6'd14, 6'd15, 6'd28, 6'd24, 6'd26: c = CLS_ALU;
            6'd32, 6'd34, 6'd40, 6'd42, 6'd58: c = CLS_LOAD;
            6'd36, 6'd37, 6'd38, 6'd44, 6'd62: c = CLS_STORE;
            6'd19:                             c = CLS_BR;
            6'd18:                             c = CLS_JMP;
            default:                           c = CLS_ILL;
        endcase
        return c;
    endfunction

    assign w_cls          = decode_cls(r_opcode, r_xo);
    assign w_swu          = (r_opcode == 6'd37);
    assign w_after_end    = start ? FETCH : IDLE;
    assign w_unused_instr = ^{instr[25:11], instr[0]};

`ifdef UPWR_MEM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            w_waiting;

    assign w_waiting = ((r_state == FETCH) && !imem_ack) || ((r_state == MEM) && !dmem_ack);
    assign w_timeout = w_waiting && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts unacknowledged request cycles, cleared on ack or state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_waiting && (w_next_state == r_state)) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; w_end marks the edge that retires an instruction.
    always_comb begin
        w_next_state = r_state;
        w_end        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = FETCH;
                end else begin
                    w_next_state = IDLE;
                end
            end
            FETCH: begin
                if (w_timeout) begin
                    w_next_state = TRAP;
                end else if (imem_ack) begin
                    w_next_state = DECODE;
                end else begin
                    w_next_state = FETCH;
                end
            end
            DECODE: begin
                if (w_cls == CLS_ILL) begin
                    w_next_state = TRAP;
                end else begin
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                case (w_cls)
                    CLS_ALU:             w_next_state = WB;
                    CLS_LOAD, CLS_STORE: w_next_state = MEM;
                    CLS_BR, CLS_JMP: begin
                        w_end        = 1'b1;
                        w_next_state = w_after_end;
                    end
                    default:             w_next_state = TRAP;
                endcase
            end
            MEM: begin
                if (w_timeout) begin
                    w_next_state = TRAP;
                end else if (dmem_ack && ((w_cls == CLS_LOAD) || w_swu)) begin
                    w_next_state = WB;
                end else if (dmem_ack) begin
                    w_end        = 1'b1;
                    w_next_state = w_after_end;
                end else begin
                    w_next_state = MEM;
                end
            end
            WB: begin
                w_end        = 1'b1;
                w_next_state = w_after_end;
            end
            TRAP:    w_next_state = TRAP;
            default: w_next_state = IDLE;
        endcase
    end

    // Output decode from current state; branch and dmem_ack act within the cycle.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        alu_en   = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 2'd0;
        busy     = 1'b1;
        case (r_state)
            IDLE:   busy = 1'b0;
            FETCH:  imem_req = 1'b1;
            DECODE: busy = 1'b1;
            EXEC: begin
                alu_en = 1'b1;
                if (w_cls == CLS_BR) begin
                    pc_we  = 1'b1;
                    pc_sel = {1'b0, branch};
                end else if (w_cls == CLS_JMP) begin
                    pc_we  = 1'b1;
                    pc_sel = 2'd2;
                end else begin
                    pc_we  = 1'b0;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (w_cls == CLS_STORE);
                if (dmem_ack && (w_cls == CLS_STORE) && !w_swu) begin
                    pc_we = 1'b1;
                end else begin
                    pc_we = 1'b0;
                end
            end
            WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                wb_sel = (w_cls == CLS_LOAD);
            end
            TRAP:    busy = 1'b0;
            default: busy = 1'b0;
        endcase
    end

    // Instruction field latch, loaded on the accepted fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode <= 6'd0;
            r_xo     <= 10'd0;
        end else if ((r_state == FETCH) && imem_ack) begin
            r_opcode <= instr[31:26];
            r_xo     <= instr[10:1];
        end else begin
            r_opcode <= r_opcode;
            r_xo     <= r_xo;
        end
    end

    // Retired counter and sticky status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
            r_illegal <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_retired <= w_end ? (r_retired + CNT_W'(1)) : r_retired;
            r_illegal <= r_illegal | ((r_state == DECODE) && (w_cls == CLS_ILL));
            r_err     <= r_err | w_timeout;
        end
    end

    assign opcode_o = r_opcode;
    assign xox_o    = (r_opcode == 6'd31) ? r_xo : 10'd0;
    assign xoxo_o   = (r_opcode == 6'd31) ? r_xo[8:0] : 9'd0;
    assign illegal  = r_illegal;
    assign err      = r_err;
    assign retired  = r_retired;

endmodule

// File: tb/tb_upower_multicycle_ctrl.sv
// Self-checking bench: directed and randomized instructions against a per-instruction
// behavioural model of classes, latencies and strobe counts.
module tb_upower_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, imem_ack, dmem_ack, branch;
    logic [31:0] instr;
    logic        imem_req, dmem_req, dmem_we, alu_en, reg_we, wb_sel, pc_we, busy, illegal, err;
    logic [5:0]  opcode_o;
    logic [9:0]  xox_o;
    logic [8:0]  xoxo_o;
    logic [1:0]  pc_sel;
    logic [31:0] retired;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_ret = 32'd0;

    localparam int C_ALU = 0, C_LOAD = 1, C_STORE = 2, C_BR = 3, C_JMP = 4, C_ILL = 5;

    int alu_ops[5]   = '{14, 15, 28, 24, 26};
    int load_ops[5]  = '{32, 34, 40, 42, 58};
    int store_ops[5] = '{36, 37, 38, 44, 62};
    int xox_l[5]     = '{28, 476, 444, 316, 986};
    int xoxo_l[2]    = '{266, 40};

    upower_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .imem_ack(imem_ack),
        .dmem_ack(dmem_ack), .branch(branch), .imem_req(imem_req), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .opcode_o(opcode_o), .xox_o(xox_o), .xoxo_o(xoxo_o),
        .alu_en(alu_en), .reg_we(reg_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
        .busy(busy), .illegal(illegal), .err(err), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_cls(input logic [31:0] w);
        int op, xox, xoxo;
        op   = int'(w[31:26]);
        xox  = int'(w[10:1]);
        xoxo = int'(w[9:1]);
        if (op == 31) return ((xoxo inside {266, 40}) || (xox inside {28, 476, 444, 316, 986})) ? C_ALU : C_ILL;
        if (op inside {14, 15, 28, 24, 26}) return C_ALU;
        if (op inside {32, 34, 40, 42, 58}) return C_LOAD;
        if (op inside {36, 37, 38, 44, 62}) return C_STORE;
        if (op == 19) return C_BR;
        if (op == 18) return C_JMP;
        return C_ILL;
    endfunction

    function automatic logic [31:0] rand_instr(input int cls);
        logic [31:0] w;
        int k;
        w = $urandom();
        k = $urandom_range(0, 4);
        case (cls)
            C_ALU: begin
                if (k == 0) begin
                    w[31:26] = 6'd31;
                    w[9:1]   = 9'(xoxo_l[$urandom_range(0, 1)]);
                end else if (k == 1) begin
                    w[31:26] = 6'd31;
                    w[10:1]  = 10'(xox_l[$urandom_range(0, 4)]);
                end else begin
                    w[31:26] = 6'(alu_ops[k]);
                end
            end
            C_LOAD:  w[31:26] = 6'(load_ops[k]);
            C_STORE: w[31:26] = 6'(store_ops[k]);
            C_BR:    w[31:26] = 6'd19;
            default: w[31:26] = 6'd18;
        endcase
        return w;
    endfunction

    // Runs one legal instruction starting in FETCH; the model predicts latency and strobes.
    task automatic run_instr(input logic [31:0] w, input int iw, input int dw, input logic br,
                             input logic st_after);
        int cls, len, n_ireq, n_dreq, n_dwe, n_alu, alu_at, n_reg, n_pcwe, pcwe_at, n_busy;
        logic [1:0]  sel_seen, exp_sel;
        logic        wbs_seen, is_mem, is_swu, writes_reg;
        logic [9:0]  exp_xox;
        cls        = model_cls(w);
        is_mem     = (cls == C_LOAD) || (cls == C_STORE);
        is_swu     = (cls == C_STORE) && (w[31:26] == 6'd37);
        writes_reg = (cls == C_ALU) || (cls == C_LOAD) || is_swu;
        len        = iw + 3 + (is_mem ? dw + 1 : 0) + (writes_reg ? 1 : 0);
        exp_sel    = (cls == C_BR) ? {1'b0, br} : ((cls == C_JMP) ? 2'd2 : 2'd0);
        exp_xox    = (w[31:26] == 6'd31) ? w[10:1] : 10'd0;
        n_ireq = 0; n_dreq = 0; n_dwe = 0; n_alu = 0; alu_at = -1; n_reg = 0;
        n_pcwe = 0; pcwe_at = -1; n_busy = 0; sel_seen = 2'd3; wbs_seen = 1'bx;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            start    = st_after;
            imem_ack = (k == iw);
            instr    = (k == iw) ? w : $urandom();
            dmem_ack = is_mem && (k == iw + 3 + dw);
            branch   = (k == iw + 2) ? br : 1'($urandom_range(0, 1));
            #1;
            n_ireq += int'(imem_req);
            n_dreq += int'(dmem_req);
            n_dwe  += int'(dmem_req & dmem_we);
            n_busy += int'(busy);
            if (alu_en) begin n_alu++; alu_at = k; end
            if (reg_we) begin n_reg++; wbs_seen = wb_sel; end
            if (pc_we)  begin n_pcwe++; pcwe_at = k; sel_seen = pc_sel; end
        end
        exp_ret = exp_ret + 32'd1;
        check("imem_req_cycles", 64'(n_ireq), 64'(iw + 1));
        check("dmem_req_cycles", 64'(n_dreq), 64'(is_mem ? dw + 1 : 0));
        check("dmem_we_cycles", 64'(n_dwe), 64'((cls == C_STORE) ? dw + 1 : 0));
        check("alu_en_count", 64'(n_alu), 64'd1);
        check("alu_en_cycle", 64'(alu_at), 64'(iw + 2));
        check("reg_we_count", 64'(n_reg), 64'(writes_reg ? 1 : 0));
        if (writes_reg) check("wb_sel", 64'(wbs_seen), 64'(cls == C_LOAD));
        check("pc_we_count", 64'(n_pcwe), 64'd1);
        check("pc_we_cycle", 64'(pcwe_at), 64'(len - 1));
        check("pc_sel", 64'(sel_seen), 64'(exp_sel));
        check("busy_cycles", 64'(n_busy), 64'(len));
        @(posedge clk);
        #1;
        check("retired", 64'(retired), 64'(exp_ret));
        check("opcode_o", 64'(opcode_o), 64'(w[31:26]));
        check("xox_o", 64'(xox_o), 64'(exp_xox));
        check("xoxo_o", 64'(xoxo_o), 64'(exp_xox[8:0]));
        check("busy_after_end", 64'(busy), 64'(st_after));
    endtask

    initial begin
        logic [31:0] w_add, w_alu14, w_bc, w_b, w_ld, w_swu, w_stw, w_bad;
        logic        idle_now, st;
        w_add   = {6'd31, 15'd0, 1'b0, 9'd266, 1'b0};
        w_alu14 = {6'd14, 26'h3ff_ffff};
        w_bc    = {6'd19, 26'h000_0000};
        w_b     = {6'd18, 26'h155_5555};
        w_ld    = {6'd32, 26'h000_1234};
        w_swu   = {6'd37, 26'h000_0042};
        w_stw   = {6'd36, 26'h000_0007};
        w_bad   = {6'd31, 15'd0, 10'd999, 1'b0};

        rst_n = 1'b0; start = 1'b0; instr = 32'd0; imem_ack = 1'b0; dmem_ack = 1'b0; branch = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_imem_req", 64'(imem_req), 64'd0);
        check("rst_dmem_req", 64'(dmem_req), 64'd0);
        check("rst_retired", 64'(retired), 64'd0);
        check("rst_flags", 64'({illegal, err, alu_en, reg_we, pc_we, pc_sel}), 64'd0);
        check("rst_fields", 64'({opcode_o, xox_o, xoxo_o}), 64'd0);
        rst_n = 1'b1;

        // Directed: ALU, branch taken/not, jump, slow load, SWU, plain store.
        @(negedge clk);
        start = 1'b1;
        run_instr(w_add, 0, 0, 1'b0, 1'b1);
        run_instr(w_alu14, 1, 0, 1'b0, 1'b1);
        run_instr(w_bc, 0, 0, 1'b1, 1'b1);
        run_instr(w_bc, 1, 0, 1'b0, 1'b1);
        run_instr(w_b, 0, 0, 1'b1, 1'b1);
        run_instr(w_ld, 0, 3, 1'b0, 1'b1);
        run_instr(w_swu, 0, 1, 1'b0, 1'b1);
        run_instr(w_stw, 2, 0, 1'b0, 1'b0);

        // Randomized legal instructions with random waits and start drops.
        idle_now = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (idle_now) begin
                @(negedge clk);
                #1;
                check("idle_busy", 64'(busy), 64'd0);
                start = 1'b1;
            end
            st = (n == 39) ? 1'b0 : ($urandom_range(0, 4) != 0);
            run_instr(rand_instr($urandom_range(0, 4)), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), st);
            idle_now = !st;
        end

        // Asynchronous reset while a load is waiting in MEM.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        instr = w_ld; imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0; dmem_ack = 1'b0;
        #1;
        check("mid_mem_req_before", 64'(dmem_req), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_mem_req_after", 64'(dmem_req), 64'd0);
        check("mid_mem_busy_after", 64'(busy), 64'd0);
        check("mid_mem_retired_after", 64'(retired), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_ret = 32'd0;

        // Undecodable op31 XO traps and stays trapped.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        instr = w_bad; imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        #1;
        check("trap_illegal", 64'(illegal), 64'd1);
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            start = n[0];
            #1;
            check("trap_hold", 64'({illegal, busy, imem_req, alu_en, pc_we}), 64'b10000);
            check("trap_retired", 64'(retired), 64'd0);
        end
`ifdef UPWR_MEM_TIMEOUT_EN
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        start = 1'b1;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            #1;
            check("to_imem_req", 64'(imem_req), 64'd1);
        end
        @(negedge clk);
        #1;
        check("to_err", 64'({err, busy, imem_req}), 64'b100);
`else
        check("err_tied_low", 64'(err), 64'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
